imem_fetch_port: RTL and testbench

//  Parametrised instruction memory with a valid/ready fetch port, 1-cycle registered read,

---
 rtl/imem_fetch_port.sv | 116 +++++++++++
 tb/tb_imem_fetch_port.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_port.sv
// Instruction memory with a valid/ready fetch port, 1-cycle registered read.
// Optional parity protection of the array: define IMEM_PARITY_EN.
module imem_fetch_port #(
    parameter int               DATA_W    = 32,
    parameter int               ADDR_W    = 10,
    parameter int               DEPTH     = 1000,
    parameter string            INIT_FILE = "",
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_fault,
    input  logic              flush,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data
);

`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    typedef enum logic {EMPTY, FULL} state_e;

    logic [MEM_W-1:0]  mem [0:DEPTH-1];

    state_e            state_q;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] addr_q;
    logic              fault_q;

    logic              accept;
    logic              take;
    logic              in_range;
    logic              wr_in_range;
    logic [MEM_W-1:0]  rd_word;
    logic [MEM_W-1:0]  wr_word;
    logic              rd_err;

    assign rsp_valid = (state_q == FULL);
    assign rsp_instr = instr_q;
    assign rsp_addr  = addr_q;
    assign rsp_fault = fault_q;

    assign req_ready = rst_n & ~prog_we & ~flush & (~rsp_valid | rsp_ready);
    assign accept    = req_valid & req_ready;
    assign take      = rsp_valid & rsp_ready;

    always_comb begin
        in_range    = {1'b0, req_addr} < DEPTH_L;
        wr_in_range = {1'b0, prog_addr} < DEPTH_L;
        rd_word     = '0;
        if (in_range) begin
            rd_word = mem[req_addr];
        end
`ifdef IMEM_PARITY_EN
        // Stored bit makes the whole word even; any odd count is corruption.
        wr_word = {^prog_data, prog_data};
        rd_err  = ^rd_word;
`else
        wr_word = prog_data;
        rd_err  = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (prog_we && wr_in_range) begin
            mem[prog_addr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            instr_q <= '0;
            addr_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) state_q <= FULL;
                end
                FULL: begin
                    if (flush) begin
                        state_q <= EMPTY;
                    end else if (take && !accept) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
            if (accept) begin
                addr_q <= req_addr;
                if (!in_range || rd_err) begin
                    instr_q <= NOP_WORD;
                    fault_q <= 1'b1;
                end else begin
                    instr_q <= rd_word[DATA_W-1:0];
                    fault_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_port.sv
// Scoreboard bench for imem_fetch_port (default DEPTH=1000, 32-bit words).
// Parity corruption case runs only when IMEM_PARITY_EN is defined.
module tb_imem_fetch_port;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int DEPTH = 1000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_instr;
    logic [AW-1:0] rsp_addr;
    logic          rsp_fault;
    logic          flush;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [DW-1:0] prog_data;

    typedef struct {
        logic [DW-1:0] instr;
        logic [AW-1:0] addr;
        logic          fault;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] mdl [0:1023];
    logic          bad [0:1023];
    logic          m_full;
    int            checks;
    int            failures;

    imem_fetch_port dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_fault (rsp_fault),
        .flush     (flush),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t expect_of(input logic [AW-1:0] a);
        exp_t e;
        e.addr = a;
        if (int'(a) >= DEPTH || bad[a]) begin
            e.instr = '0;
            e.fault = 1'b1;
        end else begin
            e.instr = mdl[a];
            e.fault = 1'b0;
        end
        return e;
    endfunction

    // One clock: check at negedge, update model, advance past posedge.
    task automatic step();
        logic  rdy;
        logic  acc;
        logic  tk;
        exp_t  e;
        @(negedge clk);
        rdy = rst_n && !prog_we && !flush && (!m_full || rsp_ready);
        check("req_ready", {63'd0, req_ready}, {63'd0, rdy});
        check("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_full});
        if (m_full && q.size() > 0) begin
            e = q[0];
            check("rsp_instr", {32'd0, rsp_instr}, {32'd0, e.instr});
            check("rsp_addr", {54'd0, rsp_addr}, {54'd0, e.addr});
            check("rsp_fault", {63'd0, rsp_fault}, {63'd0, e.fault});
        end
        acc = req_valid && rdy;
        tk  = m_full && rsp_ready;
        if (!rst_n || flush) begin
            q.delete();
            m_full = 1'b0;
        end else begin
            if (tk) void'(q.pop_front());
            if (acc) q.push_back(expect_of(req_addr));
            m_full = acc || (m_full && !tk);
        end
        if (rst_n && prog_we && int'(prog_addr) < DEPTH) begin
            mdl[prog_addr] = prog_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        flush     = 1'b0;
        prog_we   = 1'b0;
    endtask

    task automatic write(input int a, input logic [DW-1:0] d);
        idle();
        prog_we   = 1'b1;
        prog_addr = AW'(a);
        prog_data = d;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic fetch(input int a, input logic rr);
        idle();
        req_valid = 1'b1;
        req_addr  = AW'(a);
        rsp_ready = rr;
        step();
    endtask

    task automatic drain();
        idle();
        rsp_ready = 1'b1;
        step();
        step();
    endtask

    initial begin
        int addrs[10];
        addrs = '{0, 1, 2, 3, 4, 5, 6, 999, 1000, 1023};
        checks   = 0;
        failures = 0;
        m_full   = 1'b0;
        for (int i = 0; i < 1024; i++) bad[i] = 1'b0;
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_addr  = 10'd3;
        rsp_ready = 1'b1;
        flush     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        @(posedge clk);
        #1;
        step();
        step();
        check("rst_instr", {32'd0, rsp_instr}, 64'd0);
        check("rst_addr", {54'd0, rsp_addr}, 64'd0);
        check("rst_fault", {63'd0, rsp_fault}, 64'd0);
        rst_n = 1'b1;
        idle();

        write(0, 32'h0800_1000);
        write(6, 32'h0422_4000);
        write(1, 32'h0000_0013);
        write(2, 32'h1111_2222);
        write(3, 32'h3333_4444);
        write(4, 32'h5555_6666);
        write(5, 32'h1234_5678);
        write(999, 32'hDEAD_BEEF);
        write(1000, 32'hFFFF_FFFF);
        // Write with a concurrent request: request must be refused.
        prog_we   = 1'b1;
        prog_addr = 10'd2;
        prog_data = 32'hA5A5_0002;
        req_valid = 1'b1;
        req_addr  = 10'd0;
        step();
        idle();

        fetch(0, 1'b1);
        fetch(6, 1'b1);
        drain();

        fetch(0, 1'b0);
        for (int i = 0; i < 3; i++) fetch(1, 1'b0);
        fetch(1, 1'b1);
        drain();

        fetch(1000, 1'b1);
        fetch(999, 1'b1);
        fetch(1023, 1'b1);
        drain();

        fetch(2, 1'b0);
        idle();
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 10'd3;
        rsp_ready = 1'b0;
        step();
        idle();
        step();
        drain();

        for (int i = 0; i < 300; i++) begin
            idle();
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = AW'(addrs[$urandom_range(0, 9)]);
            rsp_ready = 1'($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) begin
                prog_we   = 1'b1;
                prog_addr = AW'($urandom_range(0, 6));
                prog_data = $urandom;
            end
            step();
        end
        drain();

        fetch(3, 1'b0);
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

`ifdef IMEM_PARITY_EN
        dut.mem[5][DW] = ~dut.mem[5][DW];
        bad[5] = 1'b1;
        fetch(5, 1'b1);
        fetch(4, 1'b1);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
